// File: rtl/vy_hakem.sv
// vy_hakem: two-port bus arbiter. Port 0 (l1b, instruction cache) and port 1
// (l1v, data cache) share one veri yolu request/response channel. Grants are
// round-robin. A read holds the grant until its response is delivered, and a
// write is posted: it completes as soon as the bus accepts it.
module vy_hakem #(
  parameter int ADRES_BIT = 32,
  parameter int BLOK_BIT  = 128
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // port 0 (l1b)
  input  logic [ADRES_BIT-1:0] p0_istek_adres_i,
  input  logic                 p0_istek_gecerli_i,
  input  logic                 p0_istek_yaz_i,
  input  logic [BLOK_BIT-1:0]  p0_istek_veri_i,
  output logic                 p0_istek_hazir_o,
  output logic [BLOK_BIT-1:0]  p0_veri_o,
  output logic                 p0_veri_gecerli_o,
  input  logic                 p0_veri_hazir_i,
  // port 1 (l1v)
  input  logic [ADRES_BIT-1:0] p1_istek_adres_i,
  input  logic                 p1_istek_gecerli_i,
  input  logic                 p1_istek_yaz_i,
  input  logic [BLOK_BIT-1:0]  p1_istek_veri_i,
  output logic                 p1_istek_hazir_o,
  output logic [BLOK_BIT-1:0]  p1_veri_o,
  output logic                 p1_veri_gecerli_o,
  input  logic                 p1_veri_hazir_i,
  // veri yolu side
  output logic [ADRES_BIT-1:0] vy_istek_adres_o,
  output logic                 vy_istek_gecerli_o,
  output logic                 vy_istek_yaz_o,
  output logic [BLOK_BIT-1:0]  vy_istek_veri_o,
  input  logic                 vy_istek_hazir_i,
  input  logic [BLOK_BIT-1:0]  vy_veri_i,
  input  logic                 vy_veri_gecerli_i,
  output logic                 vy_veri_hazir_o
);

  typedef enum logic [1:0] {
    BOSTA = 2'd0,  // idle, arbitrating
    ISTEK = 2'd1,  // presenting the registered request on the bus
    YANIT = 2'd2   // forwarding the read response to the granted port
  } durum_t;

  durum_t                durum_q, durum_d;
  logic                  son_kazanan_q, son_kazanan_d;  // last winning port
  logic                  g_q, g_d;                      // port owning the current transaction
  logic [ADRES_BIT-1:0]  adres_q, adres_d;
  logic                  yaz_q, yaz_d;
  logic [BLOK_BIT-1:0]   veri_q, veri_d;
  logic                  vy_gecerli_q, vy_gecerli_d;

  logic                  istek_var;  // at least one port is requesting
  logic                  g_sec;      // port that would win this cycle

  // Pick the winner: a lone requester wins, a tie goes to the port that did not win last.
  always_comb begin
    istek_var = p0_istek_gecerli_i | p1_istek_gecerli_i;
    if (p0_istek_gecerli_i && p1_istek_gecerli_i) begin
      g_sec = ~son_kazanan_q;
    end else begin
      g_sec = p1_istek_gecerli_i;
    end
  end

  // Next-state, captured payload and all combinational handshake outputs.
  always_comb begin
    // NOTE: every signal written in this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred; blocking '=' is used here
    // because later statements must see the values just computed.
    durum_d           = durum_q;
    son_kazanan_d     = son_kazanan_q;
    g_d               = g_q;
    adres_d           = adres_q;
    yaz_d             = yaz_q;
    veri_d            = veri_q;
    vy_gecerli_d      = vy_gecerli_q;
    p0_istek_hazir_o  = 1'b0;
    p1_istek_hazir_o  = 1'b0;
    p0_veri_o         = '0;
    p1_veri_o         = '0;
    p0_veri_gecerli_o = 1'b0;
    p1_veri_gecerli_o = 1'b0;
    vy_veri_hazir_o   = 1'b0;

    case (durum_q)
      BOSTA: begin
        // The grant is offered only to a requesting port, so hazir high means
        // the handshake completes on this edge.
        if (istek_var) begin
          g_d           = g_sec;
          son_kazanan_d = g_sec;
          if (g_sec) begin
            p1_istek_hazir_o = 1'b1;
            adres_d          = p1_istek_adres_i;
            yaz_d            = p1_istek_yaz_i;
            veri_d           = p1_istek_veri_i;
          end else begin
            p0_istek_hazir_o = 1'b1;
            adres_d          = p0_istek_adres_i;
            yaz_d            = p0_istek_yaz_i;
            veri_d           = p0_istek_veri_i;
          end
          vy_gecerli_d = 1'b1;
          durum_d      = ISTEK;
        end
      end

      ISTEK: begin
        if (vy_istek_hazir_i) begin
          vy_gecerli_d = 1'b0;
          // Writes are posted: nothing comes back, so arbitration resumes at once.
          durum_d      = yaz_q ? BOSTA : YANIT;
        end
      end

      YANIT: begin
        vy_veri_hazir_o = g_q ? p1_veri_hazir_i : p0_veri_hazir_i;
        if (g_q) begin
          p1_veri_o         = vy_veri_i;
          p1_veri_gecerli_o = vy_veri_gecerli_i;
        end else begin
          p0_veri_o         = vy_veri_i;
          p0_veri_gecerli_o = vy_veri_gecerli_i;
        end
        if (vy_veri_gecerli_i && vy_veri_hazir_o) begin
          durum_d = BOSTA;
        end
      end

      default: begin
        durum_d = BOSTA;
      end
    endcase
  end

  // State and payload registers; reset leaves the arbiter idle with port 0 winning the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum_q       <= BOSTA;
      son_kazanan_q <= 1'b1;
      g_q           <= 1'b0;
      // NOTE: the payload registers are reset too, because they drive the bus
      // outputs directly and those must read zero while in reset.
      adres_q       <= '0;
      yaz_q         <= 1'b0;
      veri_q        <= '0;
      vy_gecerli_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking '<=' so every register updates from the values
      // sampled at this edge, independent of statement order.
      durum_q       <= durum_d;
      son_kazanan_q <= son_kazanan_d;
      g_q           <= g_d;
      adres_q       <= adres_d;
      yaz_q         <= yaz_d;
      veri_q        <= veri_d;
      vy_gecerli_q  <= vy_gecerli_d;
    end
  end

  // The bus request is driven straight from registers.
  assign vy_istek_adres_o   = adres_q;
  assign vy_istek_gecerli_o = vy_gecerli_q;
  assign vy_istek_yaz_o     = yaz_q;
  assign vy_istek_veri_o    = veri_q;

endmodule
